// File: rtl/reg_adcfifo_burst.sv
// reg_adcfifo_burst: USB register front end serialising multi-byte words from one of several ADC FIFOs
// Ports: clk_usb/reset (sync, active-high); reg_* USB register bus (reg_datao combinational, 0 when idle);
//        fifo_empty/fifo_data/fifo_rd_en per-channel FIFO read side; underflow_flag sticky empty-read flag.
// Registers: READ streams the prefetched word LSB first, CTRL selects channel / clears stats, STAT reports flags and counters.
module reg_adcfifo_burst #(
   parameter int pBYTECNT_SIZE = 7,
   parameter int pCHANNELS = 2,
   parameter int pWORD_BYTES = 4,
   parameter logic [7:0] pADDR_READ = 8'h03,
   parameter logic [7:0] pADDR_CTRL = 8'h60,
   parameter logic [7:0] pADDR_STAT = 8'h61
) (
   input  logic                               clk_usb,
   input  logic                               reset,
   input  logic [7:0]                         reg_address,
   input  logic [pBYTECNT_SIZE-1:0]           reg_bytecnt,
   input  logic [7:0]                         reg_datai,
   output logic [7:0]                         reg_datao,
   input  logic                               reg_read,
   input  logic                               reg_write,
   input  logic [pCHANNELS-1:0]               fifo_empty,
   input  logic [pCHANNELS*pWORD_BYTES*8-1:0] fifo_data,
   output logic [pCHANNELS-1:0]               fifo_rd_en,
   output logic                               underflow_flag
);
   localparam int WW = pWORD_BYTES * 8;
   typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
   state_t state, state_nx;
   logic [3:0] ch_sel;
   logic [WW-1:0] word_buf, word_in;
   logic [2:0] byte_idx;
   logic [31:0] words_read, bc;
   logic [7:0] underflow_count, stat_byte, cur_byte;
   logic [pCHANNELS-1:0] ch_mask;
   logic read_d, armed, arm_hold;
   logic ctrl_wr, ch_new, clr, consume, good, uflow, last, cur_empty, rd_valid;
   logic unused_bits;
   assign unused_bits = ^reg_datai[7:5];
   always_comb begin
      ch_mask = pCHANNELS'(1) << ch_sel;
      cur_empty = |(fifo_empty & ch_mask);
      word_in = '0;
      for (int i = 0; i < pCHANNELS; i++)
         if (32'(ch_sel) == i) word_in = fifo_data[i*WW +: WW];
      cur_byte = '0;
      for (int i = 0; i < pWORD_BYTES; i++)
         if (32'(byte_idx) == i) cur_byte = word_buf[i*8 +: 8];
      ctrl_wr = reg_write && reg_address == pADDR_CTRL && reg_bytecnt == '0;
      // Only a different, existing channel forces a discard; out-of-range selects are dropped.
      ch_new = ctrl_wr && 32'(reg_datai[3:0]) < pCHANNELS && reg_datai[3:0] != ch_sel;
      clr = ctrl_wr && reg_datai[4];
      // A byte is delivered only if the strobe began while a word was held and is still held at the falling edge.
      consume = read_d && !reg_read && armed;
      good = consume && arm_hold && state == HOLD;
      uflow = consume && !good;
      last = byte_idx == 3'(pWORD_BYTES - 1);
      rd_valid = state == HOLD && (read_d ? arm_hold : 1'b1);
      fifo_rd_en = (state == FETCH) ? ch_mask : '0;
      bc = 32'(reg_bytecnt);
      stat_byte = (bc == 0) ? {underflow_flag, state == HOLD, cur_empty, 5'b0} :
                  (bc == 1) ? underflow_count :
                  (bc == 2) ? words_read[7:0] :
                  (bc == 3) ? words_read[15:8] :
                  (bc == 4) ? words_read[23:16] :
                  (bc == 5) ? words_read[31:24] : 8'h00;
      reg_datao = !reg_read ? 8'h00 :
                  (reg_address == pADDR_READ) ? (rd_valid ? cur_byte : 8'h00) :
                  (reg_address == pADDR_CTRL) ? {4'b0, ch_sel} :
                  (reg_address == pADDR_STAT) ? stat_byte : 8'h00;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (!cur_empty && !ch_new) ? FETCH : IDLE;
         FETCH:   state_nx = ch_new ? IDLE : WAIT;
         WAIT:    state_nx = ch_new ? IDLE : HOLD;
         HOLD:    state_nx = (ch_new || (good && last)) ? IDLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk_usb) begin
      if (reset) begin
         state <= IDLE;
         ch_sel <= '0;
         word_buf <= '0;
         byte_idx <= '0;
         words_read <= '0;
         underflow_count <= '0;
         underflow_flag <= 1'b0;
         read_d <= 1'b0;
         armed <= 1'b0;
         arm_hold <= 1'b0;
      end else begin
         state <= state_nx;
         read_d <= reg_read;
         if (reg_read && !read_d) begin
            armed <= reg_address == pADDR_READ;
            arm_hold <= state == HOLD;
         end else if (!reg_read) armed <= 1'b0;
         if (ch_new) ch_sel <= reg_datai[3:0];
         if (ch_new) begin
            word_buf <= '0;
            byte_idx <= '0;
         end else if (state == WAIT) begin
            word_buf <= word_in;
            byte_idx <= '0;
         end else if (good) byte_idx <= byte_idx + 3'd1;
         // Words popped are counted in WAIT even if a channel switch discards them there.
         words_read <= clr ? '0 : (state == WAIT) ? words_read + 32'd1 : words_read;
         underflow_count <= clr ? '0 : (uflow && underflow_count != 8'hFF) ? underflow_count + 8'd1 : underflow_count;
         underflow_flag <= clr ? 1'b0 : (uflow | underflow_flag);
      end
   end
endmodule

// File: tb/tb_reg_adcfifo_burst.sv
// tb_reg_adcfifo_burst: randomized self-checking bench for reg_adcfifo_burst against a word/byte-stream model
module tb_reg_adcfifo_burst;
   localparam int CH = 2, WB = 4;
   localparam logic [7:0] A_RD = 8'h03, A_CTRL = 8'h60, A_STAT = 8'h61;
   logic clk_usb = 1'b0, reset = 1'b1;
   logic [7:0] reg_address = '0, reg_datai = '0, reg_datao;
   logic [6:0] reg_bytecnt = '0;
   logic reg_read = 1'b0, reg_write = 1'b0;
   logic [CH-1:0] fifo_empty = '1, fifo_rd_en;
   logic [CH*WB*8-1:0] fifo_data = '0;
   logic underflow_flag;
   logic [31:0] eq [CH][$];
   logic [31:0] mq [CH][$];
   logic [7:0] hb [$];
   int ch = 0, uc = 0;
   logic [31:0] wr = '0;
   logic uf = 1'b0;
   int pops [CH];
   int checks = 0, failures = 0;

   always #5 clk_usb = ~clk_usb;

   reg_adcfifo_burst #(.pBYTECNT_SIZE(7), .pCHANNELS(CH), .pWORD_BYTES(WB),
                       .pADDR_READ(A_RD), .pADDR_CTRL(A_CTRL), .pADDR_STAT(A_STAT)) dut (
      .clk_usb(clk_usb), .reset(reset), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
      .reg_datai(reg_datai), .reg_datao(reg_datao), .reg_read(reg_read), .reg_write(reg_write),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .underflow_flag(underflow_flag));

   // One clock from negedge to negedge; the FIFO environment pops just after the edge that saw fifo_rd_en.
   task automatic cyc();
      logic [CH-1:0] p;
      p = fifo_rd_en;
      @(posedge clk_usb);
      #1;
      for (int c = 0; c < CH; c++) begin
         if (p[c] && eq[c].size() > 0) begin
            fifo_data[c*32 +: 32] = eq[c].pop_front();
            pops[c]++;
         end
         fifo_empty[c] = eq[c].size() == 0;
      end
      @(negedge clk_usb);
   endtask

   task automatic push(input int c, input logic [31:0] w);
      eq[c].push_back(w);
      mq[c].push_back(w);
      fifo_empty[c] = 1'b0;
   endtask

   // After enough idle cycles the block holds the next word of the selected channel whenever one exists.
   task automatic settle();
      logic [31:0] w;
      repeat (5) cyc();
      if (hb.size() == 0 && mq[ch].size() > 0) begin
         w = mq[ch].pop_front();
         for (int i = 0; i < WB; i++) hb.push_back(w[i*8 +: 8]);
         wr++;
      end
   endtask

   function automatic logic [7:0] exp_stat(input int b);
      case (b)
         0: return {uf, hb.size() != 0, mq[ch].size() == 0, 5'b0};
         1: return uc[7:0];
         2, 3, 4, 5: return wr[8*(b-2) +: 8];
         default: return 8'h00;
      endcase
   endfunction

   task automatic do_read(input logic [7:0] a, input int bc, output logic [7:0] d);
      reg_address = a;
      reg_bytecnt = 7'(bc);
      reg_read = 1'b1;
      cyc();
      d = reg_datao;
      reg_read = 1'b0;
      cyc();
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      reg_address = a;
      reg_bytecnt = '0;
      reg_datai = d;
      reg_write = 1'b1;
      cyc();
      reg_write = 1'b0;
   endtask

   task automatic rd_byte(output logic [7:0] got, output logic [7:0] exp);
      settle();
      if (hb.size() > 0) exp = hb.pop_front();
      else begin
         exp = 8'h00;
         uf = 1'b1;
         if (uc < 255) uc++;
      end
      do_read(A_RD, 0, got);
   endtask

   task automatic sel(input int c);
      settle();
      do_write(A_CTRL, 8'(c));
      if (c < CH && c != ch) begin
         hb.delete();
         ch = c;
      end
   endtask

   task automatic clear_stats();
      settle();
      do_write(A_CTRL, 8'h10 | 8'(ch));
      uf = 1'b0;
      uc = 0;
      wr = '0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      checks++; if (fifo_rd_en !== '0) begin failures++; $display("FAIL reset_rd_en got=%b want=0", fifo_rd_en); end
      checks++; if (reg_datao !== 8'h00) begin failures++; $display("FAIL reset_datao got=%02h want=00", reg_datao); end
      checks++; if (underflow_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b want=0", underflow_flag); end
      do_read(A_CTRL, 0, d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%02h want=00", d); end
      for (int b = 0; b < 6; b++) begin
         do_read(A_STAT, b, d);
         checks++; if (d !== exp_stat(b)) begin failures++; $display("FAIL reset_stat%0d got=%02h want=%02h", b, d, exp_stat(b)); end
      end
   endtask

   task automatic test_reset_fetch();
      logic [7:0] d, e;
      push(0, $urandom());
      push(0, $urandom());
      cyc();
      checks++; if (fifo_rd_en !== 2'b01) begin failures++; $display("FAIL fetch_rd_en got=%b want=01", fifo_rd_en); end
      reset = 1'b1;
      cyc();
      checks++; if (fifo_rd_en !== 2'b00) begin failures++; $display("FAIL rst_fetch_rd_en got=%b want=00", fifo_rd_en); end
      reset = 1'b0;
      void'(mq[0].pop_front());
      hb.delete();
      ch = 0; uf = 1'b0; uc = 0; wr = '0;
      do_read(A_RD, 0, d);
      uf = 1'b1; uc = 1;
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL early_read got=%02h want=00", d); end
      checks++; if (underflow_flag !== 1'b1) begin failures++; $display("FAIL early_flag got=%b want=1", underflow_flag); end
      settle();
      for (int b = 0; b < 6; b++) begin
         do_read(A_STAT, b, d);
         checks++; if (d !== exp_stat(b)) begin failures++; $display("FAIL rst_stat%0d got=%02h want=%02h", b, d, exp_stat(b)); end
      end
      for (int i = 0; i < WB; i++) begin
         rd_byte(d, e);
         checks++; if (d !== e) begin failures++; $display("FAIL rst_drain%0d got=%02h want=%02h", i, d, e); end
      end
      clear_stats();
      checks++; if (underflow_flag !== 1'b0) begin failures++; $display("FAIL clear_flag got=%b want=0", underflow_flag); end
   endtask

   task automatic test_basic();
      logic [7:0] d, e;
      int p0;
      push(0, 32'h44332211);
      p0 = pops[0];
      for (int i = 0; i < WB; i++) begin
         rd_byte(d, e);
         checks++; if (d !== e) begin failures++; $display("FAIL basic_byte%0d got=%02h want=%02h", i, d, e); end
      end
      settle();
      checks++; if (pops[0] - p0 !== 1) begin failures++; $display("FAIL basic_pops got=%0d want=1", pops[0] - p0); end
      for (int b = 0; b < 6; b++) begin
         do_read(A_STAT, b, d);
         checks++; if (d !== exp_stat(b)) begin failures++; $display("FAIL basic_stat%0d got=%02h want=%02h", b, d, exp_stat(b)); end
      end
   endtask

   task automatic test_underflow();
      logic [7:0] d, e;
      for (int i = 0; i < 3; i++) begin
         rd_byte(d, e);
         checks++; if (d !== e) begin failures++; $display("FAIL uflow_byte%0d got=%02h want=%02h", i, d, e); end
      end
      checks++; if (underflow_flag !== 1'b1) begin failures++; $display("FAIL uflow_flag got=%b want=1", underflow_flag); end
      for (int b = 0; b < 2; b++) begin
         do_read(A_STAT, b, d);
         checks++; if (d !== exp_stat(b)) begin failures++; $display("FAIL uflow_stat%0d got=%02h want=%02h", b, d, exp_stat(b)); end
      end
      clear_stats();
      for (int b = 0; b < 2; b++) begin
         do_read(A_STAT, b, d);
         checks++; if (d !== exp_stat(b)) begin failures++; $display("FAIL uclr_stat%0d got=%02h want=%02h", b, d, exp_stat(b)); end
      end
   endtask

   task automatic test_saturate();
      logic [7:0] d, e;
      for (int i = 0; i < 300; i++) begin
         rd_byte(d, e);
         checks++; if (d !== e) begin failures++; $display("FAIL sat_byte%0d got=%02h want=%02h", i, d, e); end
      end
      do_read(A_STAT, 1, d);
      checks++; if (d !== 8'hFF) begin failures++; $display("FAIL sat_count got=%02h want=ff", d); end
      settle();
      reg_address = A_RD;
      reg_read = 1'b1;
      cyc();
      reg_read = 1'b0;
      reg_address = A_CTRL;
      reg_bytecnt = '0;
      reg_datai = 8'h10 | 8'(ch);
      reg_write = 1'b1;
      cyc();
      reg_write = 1'b0;
      uf = 1'b0; uc = 0; wr = '0;
      checks++; if (underflow_flag !== 1'b0) begin failures++; $display("FAIL clr_vs_uflow_flag got=%b want=0", underflow_flag); end
      for (int b = 0; b < 6; b++) begin
         do_read(A_STAT, b, d);
         checks++; if (d !== exp_stat(b)) begin failures++; $display("FAIL clr_vs_uflow_stat%0d got=%02h want=%02h", b, d, exp_stat(b)); end
      end
   endtask

   task automatic test_switch();
      logic [7:0] d, e;
      int p0;
      push(0, 32'hAABBCCDD);
      push(1, 32'h01020304);
      rd_byte(d, e);
      checks++; if (d !== 8'hDD || e !== 8'hDD) begin failures++; $display("FAIL sw_first got=%02h want=dd", d); end
      p0 = pops[0];
      sel(1);
      for (int i = 0; i < 4; i++) begin
         rd_byte(d, e);
         checks++; if (d !== e) begin failures++; $display("FAIL sw_ch1_byte%0d got=%02h want=%02h", i, d, e); end
      end
      checks++; if (pops[0] !== p0) begin failures++; $display("FAIL sw_ch0_pops got=%0d want=%0d", pops[0], p0); end
      do_read(A_CTRL, 0, d);
      checks++; if (d !== 8'h01) begin failures++; $display("FAIL sw_ctrl got=%02h want=01", d); end
      sel(0);
   endtask

   task automatic test_invalid_sel();
      logic [7:0] d, e;
      push(0, $urandom());
      rd_byte(d, e);
      checks++; if (d !== e) begin failures++; $display("FAIL inv_first got=%02h want=%02h", d, e); end
      sel(15);
      do_read(A_CTRL, 0, d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL inv_ctrl got=%02h want=00", d); end
      for (int i = 1; i < WB; i++) begin
         rd_byte(d, e);
         checks++; if (d !== e) begin failures++; $display("FAIL inv_byte%0d got=%02h want=%02h", i, d, e); end
      end
   endtask

   task automatic test_random();
      logic [7:0] d, e;
      int c, n;
      for (int it = 0; it < 6; it++) begin
         c = $urandom_range(0, CH - 1);
         n = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) push(c, $urandom());
         sel(c);
         n = $urandom_range(1, 12);
         for (int k = 0; k < n; k++) begin
            rd_byte(d, e);
            checks++; if (d !== e) begin failures++; $display("FAIL rnd%0d_byte%0d got=%02h want=%02h", it, k, d, e); end
         end
         settle();
         for (int b = 0; b < 6; b++) begin
            do_read(A_STAT, b, d);
            checks++; if (d !== exp_stat(b)) begin failures++; $display("FAIL rnd%0d_stat%0d got=%02h want=%02h", it, b, d, exp_stat(b)); end
         end
      end
   endtask

   initial begin
      @(negedge clk_usb);
      test_reset();
      test_reset_fetch();
      test_basic();
      test_underflow();
      test_saturate();
      test_switch();
      test_invalid_sel();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
